// File: rtl/game_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// game_sequencer_pkg
// ----------------------------------------------------------------------------
// Shared pong definitions: game-flow state encoding, score and frame-counter
// widths, and the screen/paddle geometry used by the ball and paddle blocks.
// No ports (package).
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
package game_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 4;
  localparam int FRAME_W = 8;

  // Codes 5..7 are unused and recover to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Screen and paddle geometry shared with the ball and paddle blocks.
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int PADDLE_W  = 8;
  localparam int PADDLE_H  = 64;
  localparam int BALL_SIZE = 8;

endpackage : game_sequencer_pkg
`default_nettype wire

// File: rtl/game_sequencer_frame_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// frame_timer
// ----------------------------------------------------------------------------
// Frame-based down-counter. A synchronous load has priority over the
// tick-qualified decrement; done flags the tick that consumes the last frame.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load, load_value  synchronous load of the frame count
//   tick              one-cycle frame pulse
//   done              tick && count == 1 (combinational)
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module frame_timer
  import game_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_value,
  input  logic               tick,
  output logic               done
);

  logic [FRAME_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      // Saturate at zero so an idle timer never wraps back to 255.
      count <= count - FRAME_W'(1);
    end
  end

  assign done = tick && (count == FRAME_W'(1));

endmodule : frame_timer
`default_nettype wire

// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// game_sequencer
// ----------------------------------------------------------------------------
// Pong game-flow controller: IDLE -> SERVE -> PLAY -> POINT/OVER. Owns both
// scores, drives the ball run/centre/serve-direction controls and the score
// blink. All timing is in frames of i_frame_tick. All outputs registered.
// Ports:
//   i_clk, i_reset_n           pixel clock, asynchronous active-low reset
//   i_frame_tick               one-cycle pulse per frame
//   i_start                    start button level (rising edge used)
//   i_point1, i_point2         one-cycle point pulses from the ball block
//   o_ball_run, o_ball_center  ball motion enable / force to centre
//   o_serve_dir                1 = serve toward player 2
//   o_score1, o_score2         scores
//   o_show_scores              score display enable (blinks in OVER)
//   o_winner                   0 = player 1, 1 = player 2 (valid in OVER)
//   o_state                    current state code
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd9,
  parameter logic [FRAME_W-1:0] SERVE_FRAMES = 8'd60,
  parameter logic [FRAME_W-1:0] POINT_FRAMES = 8'd90,
  parameter logic [FRAME_W-1:0] BLINK_FRAMES = 8'd30
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_point1,
  input  logic               i_point2,
  output logic               o_ball_run,
  output logic               o_ball_center,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_score1,
  output logic [SCORE_W-1:0] o_score2,
  output logic               o_show_scores,
  output logic               o_winner,
  output logic [STATE_W-1:0] o_state
);

  state_t             state, state_nx;
  logic               start_q, start_edge;
  logic [SCORE_W-1:0] score1, score1_nx, score2, score2_nx;
  logic               serve_dir, serve_dir_nx;
  logic               winner, winner_nx;
  logic               show, show_nx;
  logic               ball_run, ball_run_nx;
  logic               ball_center, ball_center_nx;
  logic               phase_load, phase_done;
  logic [FRAME_W-1:0] phase_value;
  logic               blink_load, blink_done;

  // History resets to 1 so a button held through reset gives no edge.
  assign start_edge = i_start && !start_q;

  frame_timer u_phase_timer (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .load       (phase_load),
    .load_value (phase_value),
    .tick       (i_frame_tick),
    .done       (phase_done)
  );

  frame_timer u_blink_timer (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .load       (blink_load),
    .load_value (BLINK_FRAMES),
    .tick       (i_frame_tick),
    .done       (blink_done)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      start_q     <= 1'b1;
      score1      <= '0;
      score2      <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      show        <= 1'b1;
      ball_run    <= 1'b0;
      ball_center <= 1'b1;
    end else begin
      state       <= state_nx;
      start_q     <= i_start;
      score1      <= score1_nx;
      score2      <= score2_nx;
      serve_dir   <= serve_dir_nx;
      winner      <= winner_nx;
      show        <= show_nx;
      ball_run    <= ball_run_nx;
      ball_center <= ball_center_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    score1_nx    = score1;
    score2_nx    = score2;
    serve_dir_nx = serve_dir;
    winner_nx    = winner;
    show_nx      = 1'b1;
    phase_load   = 1'b0;
    phase_value  = SERVE_FRAMES;
    blink_load   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          score1_nx  = '0;
          score2_nx  = '0;
          phase_load = 1'b1;
          state_nx   = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (phase_done) begin
          state_nx = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A point load wins over a coincident tick because load has priority
        // inside the timer.
        if (i_point1 && i_point2) begin
          serve_dir_nx = !serve_dir;
          phase_load   = 1'b1;
          phase_value  = POINT_FRAMES;
          state_nx     = ST_POINT;
        end else if (i_point1 || i_point2) begin
          if (i_point1) begin
            score1_nx    = score1 + SCORE_W'(1);
            serve_dir_nx = 1'b0;
          end else begin
            score2_nx    = score2 + SCORE_W'(1);
            serve_dir_nx = 1'b1;
          end
          if ((score1_nx == WIN_SCORE) || (score2_nx == WIN_SCORE)) begin
            winner_nx  = i_point2;
            blink_load = 1'b1;
            state_nx   = ST_OVER;
          end else begin
            phase_load  = 1'b1;
            phase_value = POINT_FRAMES;
            state_nx    = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (phase_done) begin
          phase_load = 1'b1;
          state_nx   = ST_SERVE;
        end
      end

      ST_OVER: begin
        // Blink timer free-runs by reloading itself each half-period.
        show_nx    = show ^ blink_done;
        blink_load = blink_done;
        if (start_edge) begin
          score1_nx  = '0;
          score2_nx  = '0;
          show_nx    = 1'b1;
          phase_load = 1'b1;
          state_nx   = ST_SERVE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Ball controls are registered from the next state so they line up
    // with o_state.
    ball_run_nx    = (state_nx == ST_PLAY);
    ball_center_nx = !((state_nx == ST_PLAY) || (state_nx == ST_POINT));
  end

  assign o_ball_run    = ball_run;
  assign o_ball_center = ball_center;
  assign o_serve_dir   = serve_dir;
  assign o_score1      = score1;
  assign o_score2      = score2;
  assign o_show_scores = show;
  assign o_winner      = winner;
  assign o_state       = state;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_game_sequencer
// ----------------------------------------------------------------------------
// Directed scoreboard bench for game_sequencer (SERVE=3, POINT=2, BLINK=2,
// WIN=2). Stimulus pushes the hand-computed expected outputs; a monitor
// pops and compares on each falling edge.
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       ctr;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       show;
    logic       win;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start, point1, point2;
  logic       ball_run, ball_center, serve_dir, show_scores, winner;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  string name_q[$];
  obs_t cur;

  always #5 clk = !clk;

  game_sequencer #(
    .WIN_SCORE    (4'd2),
    .SERVE_FRAMES (8'd3),
    .POINT_FRAMES (8'd2),
    .BLINK_FRAMES (8'd2)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_frame_tick  (frame_tick),
    .i_start       (start),
    .i_point1      (point1),
    .i_point2      (point2),
    .o_ball_run    (ball_run),
    .o_ball_center (ball_center),
    .o_serve_dir   (serve_dir),
    .o_score1      (score1),
    .o_score2      (score2),
    .o_show_scores (show_scores),
    .o_winner      (winner),
    .o_state       (state)
  );

  // Ball controls follow from the state: run only in PLAY, frozen off-centre in POINT.
  function automatic obs_t with_motion(obs_t e);
    obs_t r = e;
    r.run = (e.st == ST_PLAY);
    r.ctr = !((e.st == ST_PLAY) || (e.st == ST_POINT));
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r = {state, ball_run, ball_center, serve_dir, score1, score2, show_scores, winner};
    return r;
  endfunction

  task automatic compare(input string nm, input obs_t got, input obs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d run=%0b ctr=%0b dir=%0b s1=%0d s2=%0d show=%0b win=%0b, expected st=%0d run=%0b ctr=%0b dir=%0b s1=%0d s2=%0d show=%0b win=%0b",
               nm, got.st, got.run, got.ctr, got.dir, got.s1, got.s2, got.show, got.win,
               e.st, e.run, e.ctr, e.dir, e.s1, e.s2, e.show, e.win);
    end
  endtask

  // Monitor: one expectation per clocked step, compared mid-cycle.
  always @(negedge clk) begin
    obs_t  e;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      compare(nm, sample(), e);
    end
  end

  task automatic step(input string nm, input logic tk, input logic st,
                      input logic p1, input logic p2);
    @(negedge clk);
    frame_tick = tk;
    start      = st;
    point1     = p1;
    point2     = p2;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    point1     = 1'b0;
    point2     = 1'b0;
    exp_q.push_back(with_motion(cur));
    name_q.push_back(nm);
  endtask

  // n ticked cycles with no expected change in outputs.
  task automatic hold_ticks(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; frame_tick = 1'b0; point1 = 1'b0; point2 = 1'b0;
    cur = '0; cur.st = ST_IDLE; cur.show = 1'b1;
    repeat (3) @(negedge clk);
    #1 compare("reset_values", sample(), with_motion(cur));
    @(negedge clk) rst_n = 1'b1;

    // Start held through reset gives no edge; a fresh edge serves.
    step("idle_start_held", 1'b0, 1'b1, 1'b0, 1'b0);
    step("idle_start_low",  1'b0, 1'b0, 1'b0, 1'b0);
    cur.st = ST_SERVE;
    step("start_edge",      1'b0, 1'b1, 1'b0, 1'b0);
    hold_ticks("serve_count", 2);
    cur.st = ST_PLAY;
    step("serve_done",      1'b1, 1'b0, 1'b0, 1'b0);

    // Player 1 point, point pause, re-serve.
    cur.st = ST_POINT; cur.s1 = 4'd1; cur.dir = 1'b0;
    step("point1",          1'b0, 1'b0, 1'b1, 1'b0);
    step("point_no_tick",   1'b0, 1'b0, 1'b0, 1'b0);
    hold_ticks("point_count", 1);
    cur.st = ST_SERVE;
    step("point_done",      1'b1, 1'b0, 1'b0, 1'b0);
    step("serve_ignores_point2", 1'b0, 1'b0, 1'b0, 1'b1);
    hold_ticks("serve_count2", 2);
    cur.st = ST_PLAY;
    step("serve_done2",     1'b1, 1'b0, 1'b0, 1'b0);
    step("play_ignores_start", 1'b0, 1'b1, 1'b0, 1'b0);
    step("play_start_release", 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous points: no score, direction toggles.
    cur.st = ST_POINT; cur.dir = 1'b1;
    step("double_point",    1'b0, 1'b0, 1'b1, 1'b1);
    hold_ticks("dbl_point_count", 1);
    cur.st = ST_SERVE;
    step("dbl_point_done",  1'b1, 1'b0, 1'b0, 1'b0);
    hold_ticks("serve_count3", 2);
    cur.st = ST_PLAY;
    step("serve_done3",     1'b1, 1'b0, 1'b0, 1'b0);

    // Point with coincident tick: counter loads 2, so one tick later still POINT.
    cur.st = ST_POINT; cur.s2 = 4'd1; cur.dir = 1'b1;
    step("point2_with_tick", 1'b1, 1'b0, 1'b0, 1'b1);
    hold_ticks("point_reload", 1);
    cur.st = ST_SERVE;
    step("point_done4",     1'b1, 1'b0, 1'b0, 1'b0);
    hold_ticks("serve_count4", 2);
    cur.st = ST_PLAY;
    step("serve_done4",     1'b1, 1'b0, 1'b0, 1'b0);

    // Player 2 reaches WIN_SCORE.
    cur.st = ST_OVER; cur.s2 = 4'd2; cur.win = 1'b1;
    step("win_p2",          1'b0, 1'b0, 1'b0, 1'b1);
    step("over_ignores_point", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      if ((i % 2) == 0) cur.show = !cur.show;
      step($sformatf("blink_tick%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cur.st = ST_SERVE; cur.s1 = 4'd0; cur.s2 = 4'd0; cur.show = 1'b1;
    step("over_restart",    1'b0, 1'b1, 1'b0, 1'b0);
    step("restart_release", 1'b0, 1'b0, 1'b0, 1'b0);
    hold_ticks("serve_count5", 2);
    cur.st = ST_PLAY;
    step("serve_done5",     1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of POINT.
    cur.st = ST_POINT; cur.s1 = 4'd1; cur.dir = 1'b0;
    step("p1_before_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cur = '0; cur.st = ST_IDLE; cur.show = 1'b1;
    compare("async_reset", sample(), with_motion(cur));
    @(negedge clk) rst_n = 1'b1;
    step("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_game_sequencer
`default_nettype wire
